// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit: FSM states,
// RV32I opcodes, ALU operation codes and the ALU operand select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WRITE,
        ST_WB_ALU,
        ST_WB_MEM,
        ST_BRANCH,
        ST_ILLEGAL
    } state_t;

    // Which rule the ALU decoder applies to funct3/funct7_b5
    typedef enum logic [1:0] {
        ALU_CLASS_ADD,
        ALU_CLASS_SUB,
        ALU_CLASS_R,
        ALU_CLASS_I
    } alu_class_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b1111;
    localparam logic [3:0] ALU_SRL = 4'b1110;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder. Forced classes (ADD/SUB) ignore the
// function fields; R and I classes decode funct3/funct7_b5 and flag any
// combination this CPU does not implement.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    output logic [3:0]  alu_control,
    output logic        bad_funct
);

    // Map class and function fields to an ALU code; unsupported fields raise bad_funct
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_class)
            ALU_CLASS_ADD: alu_control = ALU_ADD;
            ALU_CLASS_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: begin
                        if (alu_class == ALU_CLASS_R && funct7_b5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b111: alu_control = ALU_AND;
                    3'b110: alu_control = ALU_OR;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: begin
                        if (funct7_b5) begin
                            bad_funct = 1'b1;
                        end else begin
                            alu_control = ALU_SRL;
                        end
                    end
                    default: bad_funct = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control unit for the RV32I-subset CPU. Sequences fetch, decode,
// execute, memory and write-back, and drives datapath selects and strobes.
// Optional feature macro: MC_CTRL_PERF_EN adds cycle and retire counters.
module mc_control
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_source,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count
`endif
);

    state_t     state;
    alu_class_t alu_class;
    logic [3:0] dec_alu_control;
    logic       bad_funct;
    logic       branch_ok;

    assign branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);

    // Pick the ALU decode rule for the current state
    always_comb begin
        alu_class = ALU_CLASS_ADD;
        case (state)
            ST_EXEC_R: alu_class = ALU_CLASS_R;
            ST_EXEC_I: alu_class = ALU_CLASS_I;
            ST_BRANCH: alu_class = ALU_CLASS_SUB;
            default:   alu_class = ALU_CLASS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class   (alu_class),
        .funct3      (funct3),
        .funct7_b5   (funct7_b5),
        .alu_control (dec_alu_control),
        .bad_funct   (bad_funct)
    );

    // Main sequencer; ILLEGAL is terminal until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RST;
        end else begin
            case (state)
                ST_RST:   state <= ST_FETCH;
                ST_FETCH: if (mem_ready) state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_RTYPE:          state <= ST_EXEC_R;
                        OP_ITYPE:          state <= ST_EXEC_I;
                        OP_LOAD, OP_STORE: state <= ST_MEM_ADDR;
                        OP_BRANCH:         state <= ST_BRANCH;
                        default:           state <= ST_ILLEGAL;
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I: state <= bad_funct ? ST_ILLEGAL : ST_WB_ALU;
                ST_MEM_ADDR:  state <= (opcode == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
                ST_MEM_READ:  if (mem_ready) state <= ST_WB_MEM;
                ST_MEM_WRITE: if (mem_ready) state <= ST_FETCH;
                ST_WB_ALU, ST_WB_MEM: state <= ST_FETCH;
                ST_BRANCH:    state <= branch_ok ? ST_FETCH : ST_ILLEGAL;
                ST_ILLEGAL:   state <= ST_ILLEGAL;
                default:      state <= ST_RST;
            endcase
        end
    end

    // Decode outputs from the state; reset forces everything low immediately
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        pc_source   = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_REG;
        alu_control = ALU_AND;
        illegal     = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    mem_read    = 1'b1;
                    alu_src_a   = SRC_A_PC;
                    alu_src_b   = SRC_B_FOUR;
                    alu_control = dec_alu_control;
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_a   = SRC_A_OLD_PC;
                    alu_src_b   = SRC_B_IMM;
                    alu_control = dec_alu_control;
                end
                ST_EXEC_R: begin
                    alu_src_a   = SRC_A_REG;
                    alu_src_b   = SRC_B_REG;
                    alu_control = dec_alu_control;
                end
                ST_EXEC_I, ST_MEM_ADDR: begin
                    alu_src_a   = SRC_A_REG;
                    alu_src_b   = SRC_B_IMM;
                    alu_control = dec_alu_control;
                end
                ST_MEM_READ: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                ST_MEM_WRITE: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                ST_WB_ALU: reg_write = 1'b1;
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a   = SRC_A_REG;
                    alu_src_b   = SRC_B_REG;
                    alu_control = dec_alu_control;
                    pc_source   = 1'b1;
                    if (funct3 == 3'b000) begin
                        pc_write = zero;
                    end else if (funct3 == 3'b001) begin
                        pc_write = !zero;
                    end
                end
                ST_ILLEGAL: illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;

    assign retire = (state == ST_WB_ALU) || (state == ST_WB_MEM) ||
                    (state == ST_MEM_WRITE && mem_ready) ||
                    (state == ST_BRANCH && branch_ok);

    // Free-running cycle counter and count of instructions completing into FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count  <= 32'd0;
            retire_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (retire) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control. Each instruction is expanded into a queue of
// expected per-cycle control words from the instruction's semantics, then
// replayed against the DUT. Covers MC_CTRL_PERF_EN counters when defined.
module tb_mc_control;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_source;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t want;
        ctl_t mask;
        logic mr;
        logic z;
        logic rst;
        bit   retire;
    } step_t;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, mem_to_reg, pc_source, illegal;
    logic [1:0]  alu_src_a, alu_src_b;
    logic [3:0]  alu_control;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_count, retire_count;
`endif

    step_t       steps[$];
    int          compared = 0;
    int          mismatched = 0;
    string       cur_name;
    int unsigned exp_cycles = 0;
    int unsigned exp_retires = 0;
    bit          cnt_known = 0;
    ctl_t        full_mask;
    ctl_t        strobe_mask;

    mc_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_b5   (funct7_b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .pc_source   (pc_source),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .illegal     (illegal)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_count (cycle_count),
        .retire_count(retire_count)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Instruction mnemonic from the R/I function fields
    function automatic string mnemonic(input logic [2:0] f3, input logic b30, input bit imm);
        case (f3)
            3'b000:  return (b30 && !imm) ? "SUB" : "ADD";
            3'b111:  return "AND";
            3'b110:  return "OR";
            3'b100:  return "XOR";
            3'b101:  return b30 ? "BAD" : "SRL";
            default: return "BAD";
        endcase
    endfunction

    function automatic logic [3:0] code_of(input string mn);
        if (mn == "AND") return 4'b0000;
        if (mn == "OR")  return 4'b0001;
        if (mn == "ADD") return 4'b0010;
        if (mn == "SUB") return 4'b0110;
        if (mn == "XOR") return 4'b1111;
        return 4'b1110;
    endfunction

    task automatic push(input ctl_t want, input logic mr, input logic z, input logic rst,
                        input bit ret, input ctl_t mask);
        step_t s;
        s.want = want; s.mask = mask; s.mr = mr; s.z = z; s.rst = rst; s.retire = ret;
        steps.push_back(s);
    endtask

    task automatic push_fetch(input int fw);
        ctl_t c = '0;
        c.mem_read = 1'b1; c.src_b = 2'b01; c.alu = 4'b0010;
        repeat (fw) push(c, 1'b0, rbit(), 1'b0, 0, full_mask);
        c.pc_write = 1'b1; c.ir_write = 1'b1;
        push(c, 1'b1, rbit(), 1'b0, 0, full_mask);
    endtask

    task automatic push_decode();
        ctl_t c = '0;
        c.src_a = 2'b10; c.src_b = 2'b10; c.alu = 4'b0010;
        push(c, rbit(), rbit(), 1'b0, 0, full_mask);
    endtask

    task automatic push_mem_addr();
        ctl_t c = '0;
        c.src_a = 2'b01; c.src_b = 2'b10; c.alu = 4'b0010;
        push(c, rbit(), rbit(), 1'b0, 0, full_mask);
    endtask

    // One reset cycle (only strobes are defined) followed by the all-zero RST cycle
    task automatic push_reset();
        push('0, rbit(), rbit(), 1'b1, 0, strobe_mask);
        push('0, rbit(), rbit(), 1'b0, 0, full_mask);
    endtask

    // Expand one instruction into expected per-cycle control words
    task automatic build_instr(input logic [6:0] op, input logic [2:0] f3, input logic b30,
                               input int fw, input int mw, input logic z, input int ill_cycles,
                               output bit bad);
        ctl_t  c;
        ctl_t  m;
        bit    imm;
        string mn;
        bad = 0;
        push_fetch(fw);
        push_decode();
        case (op)
            OPC_R, OPC_I: begin
                imm = (op == OPC_I);
                mn  = mnemonic(f3, b30, imm);
                c = '0; m = full_mask;
                c.src_a = 2'b01; c.src_b = imm ? 2'b10 : 2'b00;
                if (mn == "BAD") begin
                    bad = 1; m.alu = 4'b0000;
                end else begin
                    c.alu = code_of(mn);
                end
                push(c, rbit(), rbit(), 1'b0, 0, m);
                if (!bad) begin
                    c = '0; c.reg_write = 1'b1;
                    push(c, rbit(), rbit(), 1'b0, 1, full_mask);
                end
            end
            OPC_LD: begin
                push_mem_addr();
                c = '0; c.i_or_d = 1'b1; c.mem_read = 1'b1;
                repeat (mw) push(c, 1'b0, rbit(), 1'b0, 0, full_mask);
                push(c, 1'b1, rbit(), 1'b0, 0, full_mask);
                c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                push(c, rbit(), rbit(), 1'b0, 1, full_mask);
            end
            OPC_ST: begin
                push_mem_addr();
                c = '0; c.i_or_d = 1'b1; c.mem_write = 1'b1;
                repeat (mw) push(c, 1'b0, rbit(), 1'b0, 0, full_mask);
                push(c, 1'b1, rbit(), 1'b0, 1, full_mask);
            end
            OPC_BR: begin
                c = '0;
                c.src_a = 2'b01; c.src_b = 2'b00; c.alu = 4'b0110; c.pc_source = 1'b1;
                if (f3 == 3'b000)      c.pc_write = z;
                else if (f3 == 3'b001) c.pc_write = !z;
                else                   bad = 1;
                push(c, rbit(), z, 1'b0, !bad, full_mask);
            end
            default: bad = 1;
        endcase
        if (bad) begin
            c = '0; c.illegal = 1'b1;
            repeat (ill_cycles) push(c, rbit(), rbit(), 1'b0, 0, full_mask);
        end
    endtask

    // Compare the DUT control word (and counters when present) against one step
    task automatic check_output(input step_t s, input int idx);
        logic [16:0] ov, ev, mv;
        ctl_t obs;
        obs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
               pc_source, alu_src_a, alu_src_b, alu_control, illegal};
        mv = s.mask; ov = obs; ev = s.want;
        ov = ov & mv; ev = ev & mv;
        compared++;
        assert (ov === ev) else begin
            mismatched++;
            $error("[TB] FAIL %s step %0d ctl: observed %h expected %h", cur_name, idx, ov, ev);
        end
`ifdef MC_CTRL_PERF_EN
        if (cnt_known) begin
            compared++;
            assert (cycle_count === exp_cycles) else begin
                mismatched++;
                $error("[TB] FAIL %s step %0d cycle_count: observed %0d expected %0d",
                       cur_name, idx, cycle_count, exp_cycles);
            end
            compared++;
            assert (retire_count === exp_retires) else begin
                mismatched++;
                $error("[TB] FAIL %s step %0d retire_count: observed %0d expected %0d",
                       cur_name, idx, retire_count, exp_retires);
            end
        end
`endif
    endtask

    // Replay queued steps: drive after the edge, check at the falling edge
    task automatic apply_stimulus();
        step_t s;
        int idx = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            reset = s.rst; mem_ready = s.mr; zero = s.z;
            @(negedge clk);
            check_output(s, idx);
            @(posedge clk);
            if (s.rst) begin
                exp_cycles = 0; exp_retires = 0; cnt_known = 1;
            end else begin
                exp_cycles++;
                if (s.retire) exp_retires++;
            end
            #1;
            idx++;
        end
    endtask

    task automatic do_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic b30, input int fw, input int mw, input logic z,
                            input int ill_cycles);
        bit bad;
        cur_name = name;
        opcode = op; funct3 = f3; funct7_b5 = b30;
        build_instr(op, f3, b30, fw, mw, z, ill_cycles, bad);
        apply_stimulus();
        if (bad) begin
            cur_name = {name, "/reset"};
            push_reset();
            apply_stimulus();
        end
    endtask

    // Directed sequence followed by randomized instructions
    initial begin
        ctl_t c;
        logic [6:0] rop;
        full_mask   = '1;
        strobe_mask = '0;
        strobe_mask.pc_write = 1'b1; strobe_mask.ir_write = 1'b1; strobe_mask.mem_read = 1'b1;
        strobe_mask.mem_write = 1'b1; strobe_mask.reg_write = 1'b1;

        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        opcode = '0; funct3 = '0; funct7_b5 = 1'b0;
        @(posedge clk); #1;
        cur_name = "reset";
        push_reset();
        apply_stimulus();

        do_instr("ADD",   OPC_R, 3'b000, 1'b0, 0, 0, 1'b0, 3);
        do_instr("SUB",   OPC_R, 3'b000, 1'b1, 0, 0, 1'b0, 3);
        do_instr("XOR",   OPC_R, 3'b100, 1'b0, 0, 0, 1'b0, 3);
        do_instr("SRL",   OPC_R, 3'b101, 1'b0, 0, 0, 1'b0, 3);
        do_instr("OR",    OPC_R, 3'b110, 1'b0, 0, 0, 1'b0, 3);
        do_instr("AND",   OPC_R, 3'b111, 1'b1, 0, 0, 1'b0, 3);
        do_instr("SRA_R", OPC_R, 3'b101, 1'b1, 0, 0, 1'b0, 3);
        do_instr("ADDI",  OPC_I, 3'b000, 1'b1, 1, 0, 1'b0, 3);
        do_instr("SRAI",  OPC_I, 3'b101, 1'b1, 0, 0, 1'b0, 3);
        do_instr("LW",    OPC_LD, 3'b010, 1'b0, 0, 2, 1'b0, 3);
        do_instr("SW",    OPC_ST, 3'b010, 1'b0, 1, 1, 1'b0, 3);
        do_instr("BEQ_T", OPC_BR, 3'b000, 1'b0, 0, 0, 1'b1, 3);
        do_instr("BEQ_N", OPC_BR, 3'b000, 1'b0, 0, 0, 1'b0, 3);
        do_instr("BNE_T", OPC_BR, 3'b001, 1'b0, 0, 0, 1'b0, 3);
        do_instr("BNE_N", OPC_BR, 3'b001, 1'b0, 0, 0, 1'b1, 3);
        do_instr("BLT",   OPC_BR, 3'b100, 1'b0, 0, 0, 1'b1, 3);
        do_instr("OP7F",  7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 10);

        // Store interrupted by reset while waiting on memory
        cur_name = "SW_RESET";
        opcode = OPC_ST; funct3 = 3'b010; funct7_b5 = 1'b0;
        push_fetch(0);
        push_decode();
        push_mem_addr();
        c = '0; c.i_or_d = 1'b1; c.mem_write = 1'b1;
        push(c, 1'b0, rbit(), 1'b0, 0, full_mask);
        push_reset();
        apply_stimulus();
        do_instr("ADD_AFTER_RST", OPC_R, 3'b000, 1'b0, 0, 0, 1'b0, 3);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: rop = OPC_R;
                1: rop = OPC_I;
                2: rop = OPC_LD;
                3: rop = OPC_ST;
                4: rop = OPC_BR;
                default: begin
                    rop = 7'($urandom);
                    if (rop inside {OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR}) rop = 7'h7F;
                end
            endcase
            do_instr($sformatf("rand%0d", n), rop, 3'($urandom), rbit(),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rbit(), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
